// File: rtl/lzc_ctrl_pkg.sv
// Shared constants and state type for the sequenced LZC controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lzc_ctrl_pkg;

    localparam int OP_W   = 64;
    localparam int HALF_W = 32;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } lzc_state_t;

    // Counts reported when the counted span holds no set bit.
    localparam logic [CNT_W-1:0] CNT_FULL_NARROW = 7'd32;
    localparam logic [CNT_W-1:0] CNT_FULL_WIDE   = 7'd64;

endpackage

// File: rtl/LZC_32_bit.sv
// 32-bit leading-zero counter: Z = zeros above the highest set bit, V = input nonzero.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a (32-bit operand), Z (5-bit count, meaningful only when V=1), V (valid/nonzero).
module LZC_32_bit (
    input  logic [31:0] a,
    output logic [4:0]  Z,
    output logic        V
);

    always_comb begin
        Z = 5'd0;
        // Ascending scan: the last hit is the most significant set bit.
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                Z = 5'(31 - i);
            end
        end
        V = |a;
    end

endmodule

// File: rtl/lzc_seq_arbiter.sv
// Round-robin shares one 32-bit LZC between two requesters; wide operands take two passes.
// Latency: 2 cycles after accept (narrow or nonzero high half), 3 cycles for a zero high half.
// Backpressure: result held in DONE until resp_ready; no request is accepted until back in IDLE.
//
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_wide[1:0], req_op0/req_op1[63:0];
//        resp_valid/resp_ready, resp_id, resp_count[6:0], resp_zero.
module lzc_seq_arbiter
    import lzc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [1:0]       req_wide,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [CNT_W-1:0] resp_count,
    output logic             resp_zero
);

    lzc_state_t        state_q, state_d;
    logic              last_grant_q;
    logic [OP_W-1:0]   op_q;
    logic              wide_q;
    logic              id_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              zero_q, zero_d;

    logic              gnt;
    logic              accept;
    logic [HALF_W-1:0] lzc_a;
    logic [4:0]        lzc_z;
    logic              lzc_v;
    logic [CNT_W-1:0]  lzc_z_ext;

    LZC_32_bit u_lzc (
        .a (lzc_a),
        .Z (lzc_z),
        .V (lzc_v)
    );

    assign lzc_z_ext = {{(CNT_W-5){1'b0}}, lzc_z};

    // Arbitration: on contention the port not served last wins.
    always_comb begin
        gnt       = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant_q;
            default: gnt = 1'b0;
        endcase
        if (state_q == IDLE && !rst && req_valid != 2'b00) begin
            req_ready = gnt ? 2'b10 : 2'b01;
        end
    end

    assign accept = |req_ready;

    always_comb begin
        state_d = state_q;
        lzc_a   = '0;
        count_d = count_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HI;
                end
            end
            HI: begin
                lzc_a = wide_q ? op_q[OP_W-1:HALF_W] : op_q[HALF_W-1:0];
                if (!wide_q) begin
                    count_d = lzc_v ? lzc_z_ext : CNT_FULL_NARROW;
                    zero_d  = ~lzc_v;
                    state_d = DONE;
                end else if (lzc_v) begin
                    count_d = lzc_z_ext;
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = LO;
                end
            end
            LO: begin
                // High half was empty, so the low-half count is offset by 32.
                lzc_a   = op_q[HALF_W-1:0];
                count_d = lzc_v ? (CNT_FULL_NARROW + lzc_z_ext) : CNT_FULL_WIDE;
                zero_d  = ~lzc_v;
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            wide_q       <= 1'b0;
            id_q         <= 1'b0;
            count_q      <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            if (accept) begin
                op_q         <= gnt ? req_op1 : req_op0;
                wide_q       <= req_wide[gnt];
                id_q         <= gnt;
                last_grant_q <= gnt;
            end
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_id    = id_q;
    assign resp_count = count_q;
    assign resp_zero  = zero_q;

endmodule

// File: tb/tb_lzc_seq_arbiter.sv
// Bench for lzc_seq_arbiter: directed scenarios plus randomized traffic vs. a bit-scan count model.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low in DONE.
module tb_lzc_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op0;
    logic [63:0] req_op1;
    logic [1:0]  req_wide;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [6:0]  resp_count;
    logic        resp_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lzc_seq_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_wide   (req_wide),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_count (resp_count),
        .resp_zero  (resp_zero)
    );

    // Reference: scan down from the top of the counted span until a one is found.
    function automatic void model(input logic [63:0] op, input logic wide,
                                  output int cnt, output logic zero);
        int w;
        w   = wide ? 64 : 32;
        cnt = 0;
        while (cnt < w && op[w-1-cnt] == 1'b0) cnt++;
        zero = (cnt == w);
    endfunction

    task automatic set_port(input int port, input logic [63:0] op, input logic wide);
        if (port == 0) req_op0 = op;
        else           req_op1 = op;
        req_wide[port] = wide;
    endtask

    // One complete transaction with latency, result, hold-stability and single-delivery checks.
    task automatic do_op(input int port, input logic [63:0] op, input logic wide,
                         input int hold, input logic other_busy);
        int         exp_cnt;
        logic       exp_zero;
        int         exp_lat;
        int         lat;
        int         t;
        logic [6:0] c0;
        logic       z0;
        logic       i0;
        model(op, wide, exp_cnt, exp_zero);
        exp_lat = (wide && op[63:32] == 32'h0) ? 3 : 2;

        @(negedge clk);
        set_port(port, op, wide);
        req_valid[port] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[port] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (req_ready[port] !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake port%0d: req_ready=%b required bit set", port, req_ready);
        end

        // Operands are scrambled after the handshake; the captured copy must be used.
        @(negedge clk);
        req_valid[port] = 1'b0;
        set_port(port, {$urandom, $urandom}, ~wide);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL latency op=%h wide=%b: got %0d required %0d", op, wide, lat, exp_lat);
        end
        n_cmp++;
        if (resp_id !== 1'(port)) begin
            n_fail++;
            $display("FAIL resp_id: got %b required %0d", resp_id, port);
        end
        n_cmp++;
        if (resp_count !== 7'(exp_cnt)) begin
            n_fail++;
            $display("FAIL resp_count op=%h wide=%b: got %0d required %0d", op, wide, resp_count, exp_cnt);
        end
        n_cmp++;
        if (resp_zero !== exp_zero) begin
            n_fail++;
            $display("FAIL resp_zero op=%h wide=%b: got %b required %b", op, wide, resp_zero, exp_zero);
        end

        c0 = resp_count;
        z0 = resp_zero;
        i0 = resp_id;
        if (other_busy) req_valid[1-port] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_count !== c0 || resp_zero !== z0 || resp_id !== i0) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: valid=%b count=%0d zero=%b id=%b required 1/%0d/%b/%b",
                         h, resp_valid, resp_count, resp_zero, resp_id, c0, z0, i0);
            end
            n_cmp++;
            if (req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL hold_req_ready cycle %0d: got %b required 00", h, req_ready);
            end
        end

        @(negedge clk);
        resp_ready = 1'b1;
        if (other_busy) req_valid[1-port] = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_delivery: resp_valid=%b required 0", resp_valid);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_op0    = '0;
        req_op1    = '0;
        req_wide   = 2'b00;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b required 00", req_ready);
        end
        n_cmp++;
        if ({resp_valid, resp_id, resp_count, resp_zero} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b id=%b count=%0d zero=%b required all 0",
                     resp_valid, resp_id, resp_count, resp_zero);
        end
        rst = 1'b0;
        #1;
        // last_grant starts at 1, so port 0 wins the first contention.
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b required 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_narrow();
        do_op(0, 64'hDEAD_BEEF_0001_0000, 1'b0, 0, 1'b0);
        do_op(1, 64'hFFFF_FFFF_0000_0000, 1'b0, 0, 1'b0);
        do_op(0, 64'h0000_0000_8000_0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_wide();
        do_op(1, 64'h0000_0000_0000_0F00, 1'b1, 0, 1'b0);
        do_op(0, 64'h0000_0000_0000_0000, 1'b1, 0, 1'b0);
        do_op(1, 64'h0004_0000_0000_0000, 1'b1, 0, 1'b0);
        do_op(0, 64'h0000_0000_0000_0001, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(0, 64'h0000_0000_0000_4000, 1'b0, 5, 1'b1);
        do_op(1, 64'h0000_0000_0010_0000, 1'b1, 5, 1'b1);
    endtask

    task automatic test_contention();
        int grants[$];
        int ids[$];
        int cyc;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        req_op0    = 64'h0000_0000_0000_00F0;
        req_op1    = 64'h0000_0000_0F00_0000;
        req_wide   = 2'b00;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        cyc = 0;
        while (ids.size() < 4 && cyc < 60) begin
            #1;
            n_cmp++;
            if (req_ready === 2'b11) begin
                n_fail++;
                $display("FAIL contention_onehot: req_ready=%b", req_ready);
            end
            if (req_ready != 2'b00 && grants.size() < 4) grants.push_back(int'(req_ready[1]));
            if (resp_valid === 1'b1) ids.push_back(int'(resp_id));
            @(negedge clk);
            if (grants.size() >= 4) req_valid = 2'b00;
            cyc++;
        end
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        n_cmp++;
        if (ids.size() != 4 || grants.size() != 4) begin
            n_fail++;
            $display("FAIL contention_count: grants=%0d responses=%0d required 4/4", grants.size(), ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (grants[i] != i % 2 || ids[i] != i % 2) begin
                    n_fail++;
                    $display("FAIL contention_order %0d: grant=%0d id=%0d required %0d", i, grants[i], ids[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_reset_in_lo();
        int t;
        @(negedge clk);
        set_port(0, 64'h0000_0000_0000_1234, 1'b1);
        req_valid[0] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[0] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;   // now in HI
        @(negedge clk);        // now in LO
        rst        = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_lo_no_resp cycle %0d: resp_valid=%b required 0", i, resp_valid);
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        do_op(0, 64'h0000_0000_0000_1234, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] r;
        int          sh;
        for (int n = 0; n < 10000; n++) begin
            r  = {$urandom, $urandom};
            sh = $urandom_range(0, 64);
            if (sh == 64) r = '0;
            else          r = r >> sh;
            do_op($urandom_range(0, 1), r, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_backpressure();
        test_contention();
        test_reset_in_lo();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
